// File: rtl/branch_predictor_if.sv
// Fetch/decode signal bundle between the MIPS core and the branch predictor.
// The master modport is the core side and the slave modport is the predictor side.
interface branch_predictor_if;
  logic [31:0] pc_f;
  logic        stall_d;
  logic        flush_d;
  logic        pred_taken_f;
  logic [31:0] pred_target_f;
  logic        update_en_d;
  logic [31:0] branch_pc_d;
  logic        taken_d;
  logic [31:0] target_d;
  logic        pred_taken_d;
  logic [31:0] pred_target_d;
  logic        mispredict_d;
  logic [31:0] recover_pc_d;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output pc_f, stall_d, flush_d, update_en_d, branch_pc_d, taken_d, target_d,
    input  pred_taken_f, pred_target_f, pred_taken_d, pred_target_d,
           mispredict_d, recover_pc_d, branch_count, mispredict_count
  );

  modport slave (
    input  pc_f, stall_d, flush_d, update_en_d, branch_pc_d, taken_d, target_d,
    output pred_taken_f, pred_target_f, pred_taken_d, pred_target_d,
           mispredict_d, recover_pc_d, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters, F->D prediction register and decode mispredict check.
// Define BP_PERF_CNT_EN to build the resolved-branch and mispredict counters.
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input logic              clk,
  input logic              reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [ENTRIES-1:0]  valid_q, valid_d;
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit, u_hit;

  logic                wr_en;
  logic [31:0]         wr_target;
  logic [1:0]          wr_ctr;

  logic                fd_taken_q, fd_taken_d;
  logic [31:0]         fd_target_q, fd_target_d;
  logic                mispredict;
  logic                unused_pc_bits;

  assign f_idx = bp.pc_f[INDEX_BITS+1:2];
  assign f_tag = bp.pc_f[31:INDEX_BITS+2];
  assign u_idx = bp.branch_pc_d[INDEX_BITS+1:2];
  assign u_tag = bp.branch_pc_d[31:INDEX_BITS+2];
  assign unused_pc_bits = ^bp.pc_f[1:0];

  // Lookup reads current table state only; same-cycle updates are not bypassed.
  assign f_hit            = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign bp.pred_taken_f  = f_hit && ctr_q[f_idx][1];
  assign bp.pred_target_f = bp.pred_taken_f ? target_q[f_idx] : 32'h0;

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    valid_d   = valid_q;
    wr_en     = 1'b0;
    wr_target = target_q[u_idx];
    wr_ctr    = ctr_q[u_idx];
    if (bp.update_en_d) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (bp.taken_d) begin
          wr_ctr    = (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
          wr_target = bp.target_d;
        end else begin
          wr_ctr    = (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
        end
      end else if (bp.taken_d) begin
        wr_en          = 1'b1;
        valid_d[u_idx] = 1'b1;
        wr_target      = bp.target_d;
        wr_ctr         = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Payload fields need no reset: they are only observed behind a valid bit.
  always_ff @(posedge clk) begin
    if (wr_en && reset) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= wr_target;
      ctr_q[u_idx]    <= wr_ctr;
    end
  end

  always_comb begin
    fd_taken_d  = fd_taken_q;
    fd_target_d = fd_target_q;
    if (bp.flush_d) begin
      fd_taken_d  = 1'b0;
      fd_target_d = 32'h0;
    end else if (!bp.stall_d) begin
      fd_taken_d  = bp.pred_taken_f;
      fd_target_d = bp.pred_target_f;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fd_taken_q  <= 1'b0;
      fd_target_q <= 32'h0;
    end else begin
      fd_taken_q  <= fd_taken_d;
      fd_target_q <= fd_target_d;
    end
  end

  assign bp.pred_taken_d  = fd_taken_q;
  assign bp.pred_target_d = fd_target_q;

  assign mispredict = bp.update_en_d &&
                      ((bp.taken_d != fd_taken_q) || (bp.taken_d && (bp.target_d != fd_target_q)));
  assign bp.mispredict_d = mispredict;
  assign bp.recover_pc_d = (bp.update_en_d && bp.taken_d) ? bp.target_d : bp.branch_pc_d + 32'd4;

`ifdef BP_PERF_CNT_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] misp_cnt_q, misp_cnt_d;

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    misp_cnt_d   = misp_cnt_q;
    if (bp.update_en_d) branch_cnt_d = branch_cnt_q + 32'd1;
    if (mispredict)     misp_cnt_d   = misp_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q <= 32'h0;
      misp_cnt_q   <= 32'h0;
    end else begin
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end

  assign bp.branch_count     = branch_cnt_q;
  assign bp.mispredict_count = misp_cnt_q;
`else
  assign bp.branch_count     = 32'h0;
  assign bp.mispredict_count = 32'h0;
`endif
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// against a table-of-entries reference model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  branch_predictor_if bpif ();
  branch_predictor #(.INDEX_BITS(4)) dut (.clk(clk), .reset(reset), .bp(bpif));

  always #5 clk = ~clk;

  // Reference model: 16 entries, counter kept as a plain integer 0..3.
  bit          m_valid  [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];
  bit          m_pt_d;
  logic [31:0] m_ptgt_d;
  logic [31:0] m_bc, m_mc;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
    m_pt_d = 0; m_ptgt_d = 0; m_bc = 0; m_mc = 0;
  endfunction

  function automatic void m_lookup(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int idx = int'((pc / 4) % 16);
    bit hit = m_valid[idx] && (m_tag[idx] == pc / 64);
    t  = hit && (m_ctr[idx] >= 2);
    tg = t ? m_target[idx] : 32'h0;
  endfunction

  function automatic bit m_misp();
    if (!bpif.update_en_d) return 0;
    if (bpif.taken_d != m_pt_d) return 1;
    return bpif.taken_d && (bpif.target_d != m_ptgt_d);
  endfunction

  function automatic logic [31:0] m_recover();
    if (bpif.update_en_d && bpif.taken_d) return bpif.target_d;
    return bpif.branch_pc_d + 32'd4;
  endfunction

  function automatic void model_edge();
    bit t; logic [31:0] tg; int idx; bit hit;
    if (!reset) return;
    m_lookup(bpif.pc_f, t, tg);
    if (bpif.update_en_d) m_bc = m_bc + 1;
    if (m_misp()) m_mc = m_mc + 1;
    if (bpif.update_en_d) begin
      idx = int'((bpif.branch_pc_d / 4) % 16);
      hit = m_valid[idx] && (m_tag[idx] == bpif.branch_pc_d / 64);
      if (hit && bpif.taken_d) begin
        m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3;
        m_target[idx] = bpif.target_d;
      end else if (hit) begin
        m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
      end else if (bpif.taken_d) begin
        m_valid[idx] = 1; m_tag[idx] = bpif.branch_pc_d / 64;
        m_target[idx] = bpif.target_d; m_ctr[idx] = 2;
      end
    end
    if (bpif.flush_d) begin
      m_pt_d = 0; m_ptgt_d = 0;
    end else if (!bpif.stall_d) begin
      m_pt_d = t; m_ptgt_d = tg;
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_upd(input bit en, input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    bpif.update_en_d = en; bpif.branch_pc_d = pc; bpif.taken_d = tk; bpif.target_d = tg;
  endtask

  // One-cycle update, leaving the update port idle afterwards.
  task automatic do_update(input logic [31:0] pc, input bit tk, input logic [31:0] tg);
    set_upd(1, pc, tk, tg);
    cycle();
    set_upd(0, 32'h0, 0, 32'h0);
  endtask

  function automatic logic [31:0] pick_pc();
    int r = int'($urandom_range(0, 40));
    if (r == 40) return 32'hFFFF_FFFC;
    return 32'h0040_0000 + 32'(r * 4);
  endfunction

  task automatic test_reset();
    reset = 0; m_reset();
    bpif.pc_f = 32'h0; bpif.stall_d = 0; bpif.flush_d = 0;
    set_upd(0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bpif.pred_taken_d !== 1'b0) begin errors++; $display("FAIL reset_pred_taken_d got %b exp 0", bpif.pred_taken_d); end
    checks++; if (bpif.pred_target_d !== 32'h0) begin errors++; $display("FAIL reset_pred_target_d got %h exp 0", bpif.pred_target_d); end
    reset = 1;
    bpif.pc_f = 32'h0040_0010;
    #1;
    checks++; if (bpif.pred_taken_f !== 1'b0) begin errors++; $display("FAIL reset_lookup_taken got %b exp 0", bpif.pred_taken_f); end
    checks++; if (bpif.pred_target_f !== 32'h0) begin errors++; $display("FAIL reset_lookup_target got %h exp 0", bpif.pred_target_f); end
    cycle();
    checks++; if (bpif.pred_taken_d !== 1'b0) begin errors++; $display("FAIL reset_fd_taken got %b exp 0", bpif.pred_taken_d); end
    checks++; if (bpif.branch_count !== 32'h0) begin errors++; $display("FAIL reset_branch_count got %h exp 0", bpif.branch_count); end
    checks++; if (bpif.mispredict_count !== 32'h0) begin errors++; $display("FAIL reset_misp_count got %h exp 0", bpif.mispredict_count); end
    $display("test_reset done");
  endtask

  task automatic test_allocate();
    bpif.pc_f = 32'h0040_0010;
    set_upd(1, 32'h0040_0010, 1, 32'h0040_0040);
    #1;
    checks++; if (bpif.mispredict_d !== 1'b1) begin errors++; $display("FAIL alloc_misp got %b exp 1", bpif.mispredict_d); end
    checks++; if (bpif.recover_pc_d !== 32'h0040_0040) begin errors++; $display("FAIL alloc_recover got %h exp 00400040", bpif.recover_pc_d); end
    checks++; if (bpif.pred_taken_f !== 1'b0) begin errors++; $display("FAIL alloc_no_bypass got %b exp 0", bpif.pred_taken_f); end
    cycle();
    set_upd(0, 32'h0, 0, 32'h0);
    #1;
    checks++; if (bpif.pred_taken_f !== 1'b1) begin errors++; $display("FAIL alloc_hit_taken got %b exp 1", bpif.pred_taken_f); end
    checks++; if (bpif.pred_target_f !== 32'h0040_0040) begin errors++; $display("FAIL alloc_hit_target got %h exp 00400040", bpif.pred_target_f); end
    $display("test_allocate done");
  endtask

  task automatic test_saturation();
    bpif.pc_f = 32'h0000_1000;
    do_update(32'h0040_0010, 1, 32'h0040_0040);
    do_update(32'h0040_0010, 1, 32'h0040_0040);
    do_update(32'h0040_0010, 0, 32'h0);
    bpif.pc_f = 32'h0040_0010; #1;
    checks++; if (bpif.pred_taken_f !== 1'b1) begin errors++; $display("FAIL sat_ctr10_taken got %b exp 1", bpif.pred_taken_f); end
    bpif.pc_f = 32'h0000_1000;
    do_update(32'h0040_0010, 0, 32'h0);
    bpif.pc_f = 32'h0040_0010; #1;
    checks++; if (bpif.pred_taken_f !== 1'b0) begin errors++; $display("FAIL sat_ctr01_taken got %b exp 0", bpif.pred_taken_f); end
    cycle();
    set_upd(1, 32'h0040_0010, 0, 32'h0);
    #1;
    checks++; if (bpif.mispredict_d !== 1'b0) begin errors++; $display("FAIL sat_nt_misp got %b exp 0", bpif.mispredict_d); end
    checks++; if (bpif.recover_pc_d !== 32'h0040_0014) begin errors++; $display("FAIL sat_nt_recover got %h exp 00400014", bpif.recover_pc_d); end
    cycle();
    set_upd(0, 32'h0, 0, 32'h0);
    $display("test_saturation done");
  endtask

  task automatic test_aliasing();
    bpif.pc_f = 32'h0000_1000;
    do_update(32'h0040_0010, 1, 32'h0040_0040);
    do_update(32'h0040_0010, 1, 32'h0040_0040);
    bpif.pc_f = 32'h0040_0010; #1;
    checks++; if (bpif.pred_target_f !== 32'h0040_0040) begin errors++; $display("FAIL alias_orig_target got %h exp 00400040", bpif.pred_target_f); end
    bpif.pc_f = 32'h0040_0050; #1;
    checks++; if (bpif.pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_tag_miss got %b exp 0", bpif.pred_taken_f); end
    do_update(32'h0040_0050, 1, 32'h0040_0100);
    #1;
    checks++; if (bpif.pred_target_f !== 32'h0040_0100) begin errors++; $display("FAIL alias_new_target got %h exp 00400100", bpif.pred_target_f); end
    bpif.pc_f = 32'h0040_0010; #1;
    checks++; if (bpif.pred_taken_f !== 1'b0) begin errors++; $display("FAIL alias_evicted got %b exp 0", bpif.pred_taken_f); end
    $display("test_aliasing done");
  endtask

  task automatic test_stall_flush();
    bpif.pc_f = 32'h0040_0050;
    cycle();
    checks++; if (bpif.pred_target_d !== 32'h0040_0100) begin errors++; $display("FAIL fd_capture got %h exp 00400100", bpif.pred_target_d); end
    bpif.stall_d = 1;
    for (int i = 0; i < 3; i++) begin
      bpif.pc_f = pick_pc();
      cycle();
      checks++; if (bpif.pred_taken_d !== 1'b1 || bpif.pred_target_d !== 32'h0040_0100) begin
        errors++; $display("FAIL stall_hold got %b/%h exp 1/00400100", bpif.pred_taken_d, bpif.pred_target_d);
      end
    end
    bpif.flush_d = 1; bpif.pc_f = 32'h0040_0050;
    cycle();
    checks++; if (bpif.pred_taken_d !== 1'b0 || bpif.pred_target_d !== 32'h0) begin
      errors++; $display("FAIL flush_over_stall got %b/%h exp 0/00000000", bpif.pred_taken_d, bpif.pred_target_d);
    end
    bpif.flush_d = 0; bpif.stall_d = 0;
    $display("test_stall_flush done");
  endtask

  task automatic test_random();
    bit t; logic [31:0] tg;
    for (int n = 0; n < 400; n++) begin
      bpif.pc_f    = pick_pc();
      bpif.stall_d = ($urandom_range(0, 7) == 0);
      bpif.flush_d = ($urandom_range(0, 11) == 0);
      set_upd($urandom_range(0, 2) != 0, pick_pc(), $urandom_range(0, 2) != 0,
              32'h0040_0000 + 32'($urandom_range(0, 7) * 64));
      #1;
      m_lookup(bpif.pc_f, t, tg);
      checks++; if (bpif.pred_taken_f !== t) begin errors++; $display("FAIL rnd_pred_taken_f n=%0d got %b exp %b", n, bpif.pred_taken_f, t); end
      checks++; if (bpif.pred_target_f !== tg) begin errors++; $display("FAIL rnd_pred_target_f n=%0d got %h exp %h", n, bpif.pred_target_f, tg); end
      checks++; if (bpif.pred_taken_d !== m_pt_d || bpif.pred_target_d !== m_ptgt_d) begin
        errors++; $display("FAIL rnd_fd n=%0d got %b/%h exp %b/%h", n, bpif.pred_taken_d, bpif.pred_target_d, m_pt_d, m_ptgt_d);
      end
      checks++; if (bpif.mispredict_d !== m_misp()) begin errors++; $display("FAIL rnd_misp n=%0d got %b exp %b", n, bpif.mispredict_d, m_misp()); end
      checks++; if (bpif.recover_pc_d !== m_recover()) begin errors++; $display("FAIL rnd_recover n=%0d got %h exp %h", n, bpif.recover_pc_d, m_recover()); end
`ifdef BP_PERF_CNT_EN
      checks++; if (bpif.branch_count !== m_bc || bpif.mispredict_count !== m_mc) begin
        errors++; $display("FAIL rnd_counters n=%0d got %0d/%0d exp %0d/%0d", n, bpif.branch_count, bpif.mispredict_count, m_bc, m_mc);
      end
`endif
      cycle();
    end
    bpif.stall_d = 0; bpif.flush_d = 0;
    set_upd(0, 32'h0, 0, 32'h0);
    $display("test_random done");
  endtask

  task automatic test_reset_midrun();
    bpif.pc_f = 32'h0000_1000;
    do_update(32'h0040_0030, 1, 32'h0040_0200);
    bpif.pc_f = 32'h0040_0030;
    cycle();
    checks++; if (bpif.pred_taken_d !== 1'b1) begin errors++; $display("FAIL mid_pre_taken_d got %b exp 1", bpif.pred_taken_d); end
    bpif.pc_f = 32'h0000_1000;
    set_upd(1, 32'h0040_0020, 1, 32'h0040_0300);
    #2;
    reset = 0; m_reset();
    #1;
    checks++; if (bpif.pred_taken_d !== 1'b0 || bpif.pred_target_d !== 32'h0) begin
      errors++; $display("FAIL mid_async_clear got %b/%h exp 0/00000000", bpif.pred_taken_d, bpif.pred_target_d);
    end
    cycle();
    set_upd(0, 32'h0, 0, 32'h0);
    reset = 1;
    bpif.pc_f = 32'h0040_0030; #1;
    checks++; if (bpif.pred_taken_f !== 1'b0) begin errors++; $display("FAIL mid_old_entry got %b exp 0", bpif.pred_taken_f); end
    bpif.pc_f = 32'h0040_0020; #1;
    checks++; if (bpif.pred_taken_f !== 1'b0) begin errors++; $display("FAIL mid_discarded_update got %b exp 0", bpif.pred_taken_f); end
    checks++; if (bpif.branch_count !== 32'h0 || bpif.mispredict_count !== 32'h0) begin
      errors++; $display("FAIL mid_counters_clear got %0d/%0d exp 0/0", bpif.branch_count, bpif.mispredict_count);
    end
    bpif.pc_f = 32'h0000_1000;
    do_update(32'h0040_0040, 1, 32'h0040_0400);
    do_update(32'h0040_0040, 0, 32'h0);
    do_update(32'h0040_0044, 0, 32'h0);
    do_update(32'h0040_0048, 1, 32'h0040_0500);
    do_update(32'h0040_0048, 0, 32'h0);
    #1;
`ifdef BP_PERF_CNT_EN
    checks++; if (bpif.branch_count !== 32'd5) begin errors++; $display("FAIL cnt_branch got %0d exp 5", bpif.branch_count); end
    checks++; if (bpif.mispredict_count !== 32'd2) begin errors++; $display("FAIL cnt_misp got %0d exp 2", bpif.mispredict_count); end
`else
    checks++; if (bpif.branch_count !== 32'd0) begin errors++; $display("FAIL cnt_branch_tied got %0d exp 0", bpif.branch_count); end
    checks++; if (bpif.mispredict_count !== 32'd0) begin errors++; $display("FAIL cnt_misp_tied got %0d exp 0", bpif.mispredict_count); end
`endif
    checks++; if (m_bc !== 32'd5 || m_mc !== 32'd2) begin errors++; $display("FAIL cnt_model got %0d/%0d exp 5/2", m_bc, m_mc); end
    $display("test_reset_midrun done");
  endtask

  initial begin
    test_reset();
    test_allocate();
    test_saturation();
    test_aliasing();
    test_stall_flush();
    test_random();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
